// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces the reset button, synchronises PLL lock flags and
// releases the domain resets in order once everything has been stable long enough.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ASSERT  | all domains held in reset, waiting for button released + locked
// PLLRST  | pll_rstn driven low for PLL_RST_CYCLES, domains held
// STRETCH | conditions good, counting STRETCH_CYCLES before first release
// RELEASE | clearing domain_reset bits one per GAP_CYCLES, lowest first
// RUN     | every domain released
module reset_sequencer #(
   parameter int NUM_DOMAINS     = 3,
   parameter int NUM_LOCKS       = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STRETCH_CYCLES  = 64,
   parameter int GAP_CYCLES      = 8,
   parameter int PLL_RST_CYCLES  = 32
) (
   input  logic                   io_systemClk,
   input  logic                   io_systemReset,
   input  logic                   io_asyncResetn_in,
   input  logic [NUM_LOCKS-1:0]   pll_locked,
   input  logic                   pll_rst_req,
   output logic                   pll_rstn,
   output logic [NUM_DOMAINS-1:0] domain_reset,
   output logic                   all_released,
   output logic [2:0]             seq_state,
   output logic [7:0]             lock_lost_count
);

   localparam int SEQ_MAX_A = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
   localparam int SEQ_MAX   = (SEQ_MAX_A > PLL_RST_CYCLES) ? SEQ_MAX_A : PLL_RST_CYCLES;
   localparam int SEQ_W     = $clog2(SEQ_MAX + 1);
   localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_ASSERT  = 3'd0,
      ST_PLLRST  = 3'd1,
      ST_STRETCH = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   logic                   btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [NUM_LOCKS-1:0]   lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
   logic                   pressed_q, pressed_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   state_t                 state_q, state_d;
   logic [SEQ_W-1:0]       cnt_q, cnt_d;
   logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
   logic                   pll_rstn_q, pll_rstn_d;
   logic                   all_released_q, all_released_d;
   logic [7:0]             lock_lost_q, lock_lost_d;

   logic                   all_locked, fault, btn_low;
   logic [NUM_DOMAINS-1:0] dr_shift;

   assign all_locked = &lock_s2_q;
   assign fault      = pressed_q | ~all_locked;
   assign btn_low    = ~btn_s2_q;
   assign dr_shift   = domain_reset_q << 1;

   always_comb begin
      btn_s1_d  = io_asyncResetn_in;
      btn_s2_d  = btn_s1_q;
      lock_s1_d = pll_locked;
      lock_s2_d = lock_s1_q;
   end

   // Any sample agreeing with the current debounced state restarts the run.
   always_comb begin
      pressed_d = pressed_q;
      db_cnt_d  = '0;
      if (btn_low != pressed_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) pressed_d = btn_low;
         else db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      domain_reset_d = domain_reset_q;
      pll_rstn_d     = pll_rstn_q;
      all_released_d = all_released_q;
      lock_lost_d    = lock_lost_q;

      if (pll_rst_req && state_q != ST_PLLRST) begin
         state_d        = ST_PLLRST;
         cnt_d          = '0;
         domain_reset_d = '1;
         pll_rstn_d     = 1'b0;
         all_released_d = 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               domain_reset_d = '1;
               all_released_d = 1'b0;
               pll_rstn_d     = 1'b1;
               cnt_d          = '0;
               if (!fault) state_d = ST_STRETCH;
            end
            ST_PLLRST: begin
               domain_reset_d = '1;
               all_released_d = 1'b0;
               if (cnt_q == SEQ_W'(PLL_RST_CYCLES - 1)) begin
                  pll_rstn_d = 1'b1;
                  cnt_d      = '0;
                  state_d    = ST_ASSERT;
               end else begin
                  pll_rstn_d = 1'b0;
                  cnt_d      = cnt_q + 1'b1;
               end
            end
            ST_STRETCH: begin
               if (fault) begin
                  state_d        = ST_ASSERT;
                  domain_reset_d = '1;
                  cnt_d          = '0;
               end else if (cnt_q == SEQ_W'(STRETCH_CYCLES - 1)) begin
                  cnt_d          = '0;
                  domain_reset_d = dr_shift;
                  // A single domain is fully released by its first clear.
                  if (dr_shift == '0) begin
                     state_d        = ST_RUN;
                     all_released_d = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RELEASE, ST_RUN: begin
               if (fault) begin
                  state_d        = ST_ASSERT;
                  domain_reset_d = '1;
                  all_released_d = 1'b0;
                  cnt_d          = '0;
                  if (!all_locked && lock_lost_q != 8'hFF) lock_lost_d = lock_lost_q + 1'b1;
               end else if (state_q == ST_RELEASE) begin
                  if (cnt_q == SEQ_W'(GAP_CYCLES - 1)) begin
                     cnt_d          = '0;
                     domain_reset_d = dr_shift;
                     if (dr_shift == '0) begin
                        state_d        = ST_RUN;
                        all_released_d = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d        = ST_ASSERT;
               domain_reset_d = '1;
               all_released_d = 1'b0;
               pll_rstn_d     = 1'b1;
               cnt_d          = '0;
            end
         endcase
      end
   end

   always_ff @(posedge io_systemClk) begin
      if (io_systemReset) begin
         btn_s1_q       <= 1'b1;
         btn_s2_q       <= 1'b1;
         lock_s1_q      <= '0;
         lock_s2_q      <= '0;
         pressed_q      <= 1'b0;
         db_cnt_q       <= '0;
         state_q        <= ST_ASSERT;
         cnt_q          <= '0;
         domain_reset_q <= '1;
         pll_rstn_q     <= 1'b1;
         all_released_q <= 1'b0;
         lock_lost_q    <= '0;
      end else begin
         btn_s1_q       <= btn_s1_d;
         btn_s2_q       <= btn_s2_d;
         lock_s1_q      <= lock_s1_d;
         lock_s2_q      <= lock_s2_d;
         pressed_q      <= pressed_d;
         db_cnt_q       <= db_cnt_d;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         domain_reset_q <= domain_reset_d;
         pll_rstn_q     <= pll_rstn_d;
         all_released_q <= all_released_d;
         lock_lost_q    <= lock_lost_d;
      end
   end

   assign pll_rstn        = pll_rstn_q;
   assign domain_reset    = domain_reset_q;
   assign all_released    = all_released_q;
   assign seq_state       = state_q;
   assign lock_lost_count = lock_lost_q;

endmodule
